stopwatch_counter: RTL

//  Time-keeping core of the stopwatch. Produces the minutes/seconds values and pause status consumed by the display stage.

---
 rtl/stopwatch_counter_pkg.sv | 16 +
 rtl/stopwatch_counter_mod_counter.sv | 45 ++++
 rtl/stopwatch_counter.sv | 109 ++++++++++
 3 files changed

// File: rtl/stopwatch_counter_pkg.sv
// rtl/stopwatch_counter_pkg.sv - shared state encoding and default limits for the stopwatch
// Purpose: state encoding and default count limits, shared by the time-keeping core
//          and the display stage.
// Ports:   none (package).
package stopwatch_counter_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    localparam int DEF_CNT_W   = 6;
    localparam int DEF_MAX_MIN = 59;
    localparam int DEF_MAX_SEC = 59;

endpackage

// File: rtl/stopwatch_counter_mod_counter.sv
// rtl/stopwatch_counter_mod_counter.sv - modulo-(MAX+1) up counter with wrap flag
// Purpose: counts 0..MAX, stepping by one on each inc; MAX wraps to 0.
// Ports:   clk   - clock
//          reset - asynchronous active-high reset, clears value
//          inc   - step enable
//          value - current count, registered
//          wrap  - inc while value==MAX (the counter returns to 0 this edge)
module mod_counter #(
    parameter int CNT_W = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    assign wrap = inc & (value_q == MAX_V);

    always_comb begin
        value_d = value_q;
        if (wrap) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS stopwatch core with pause toggle and adjust mode
// Purpose: counts MM:SS on tick1Hz while running; adjust mode steps minutes or
//          seconds on tick2Hz; a rising edge of pauseBtn toggles run/pause.
// Ports:   clk      - system clock
//          reset    - asynchronous active-high reset
//          tick1Hz  - 1 Hz single-cycle enable
//          tick2Hz  - 2 Hz single-cycle enable
//          pauseBtn - debounced pause button level
//          adjust   - 1 = adjust mode
//          select   - in adjust mode: 0 = step minutes, 1 = step seconds
//          minutes  - current minutes, registered
//          seconds  - current seconds, registered
//          pause    - 1 while paused, registered
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick1Hz,
    input  logic             tick2Hz,
    input  logic             pauseBtn,
    input  logic             adjust,
    input  logic             select,
    output logic [CNT_W-1:0] minutes,
    output logic [CNT_W-1:0] seconds,
    output logic             pause
);

    state_t state_q;
    state_t state_d;
    logic   pause_btn_q;
    logic   pause_btn_d;
    // Set once the button has been seen released after reset, so a button held
    // through reset release cannot produce a toggle until it is pressed again.
    logic   armed_q;
    logic   armed_d;
    logic   pause_edge;

    logic adj_step;
    logic run_tick;
    logic sec_inc;
    logic min_inc;
    logic sec_wrap;
    logic min_wrap_unused;

    assign pause_edge = pauseBtn & ~pause_btn_q & armed_q;

    always_comb begin
        state_d     = state_q;
        pause_btn_d = pauseBtn;
        armed_d     = armed_q | ~pauseBtn;
        if (pause_edge) begin
            case (state_q)
                ST_RUN:    state_d = ST_PAUSED;
                ST_PAUSED: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pause_btn_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_btn_q <= pause_btn_d;
            armed_q     <= armed_d;
        end
    end

    // Count enables use the pre-edge state, so a tick coinciding with a pause
    // edge in RUN still counts once. Adjust mode masks tick1Hz entirely.
    assign adj_step = adjust & tick2Hz;
    assign run_tick = ~adjust & (state_q == ST_RUN) & tick1Hz;
    assign sec_inc  = (adj_step & select) | run_tick;
    // Seconds wrap only carries in run mode; adjusting seconds never moves minutes.
    assign min_inc  = (adj_step & ~select) | (run_tick & sec_wrap);

    mod_counter #(
        .CNT_W (CNT_W),
        .MAX   (MAX_SEC)
    ) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .value (seconds),
        .wrap  (sec_wrap)
    );

    mod_counter #(
        .CNT_W (CNT_W),
        .MAX   (MAX_MIN)
    ) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .value (minutes),
        .wrap  (min_wrap_unused)
    );

    assign pause = (state_q == ST_PAUSED);

endmodule
